// File: rtl/issue_pkg.sv
// issue_pkg: types shared by the issue queue and the execution units that feed the CDB.
//   mul_op_t    - multiply operation encoding (MUL, MULH, MULHSU, MULHU)
//   TAG_W       - physical tag width, matching the issue queue and the CDB
//   DATA_W      - CDB data width
//   cdb_bcast_t - CDB broadcast record {tag, data, valid}
package issue_pkg;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              valid;
    } cdb_bcast_t;
endpackage

// File: rtl/mult_core.sv
// mult_core: unsigned radix-2 shift-add multiplier datapath, one iteration per step.
//   clk, rst - clock and asynchronous active-high reset
//   start    - load operands a/b, clear accumulator and counter
//   step     - perform one shift-add iteration
//   a, b     - unsigned multiplicand and multiplier
//   prod     - accumulator value after the current iteration (valid to capture with done)
//   done     - the current step is the last of XLEN iterations
module mult_core #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                step,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic [2*XLEN-1:0]   prod,
    output logic                done
);
    localparam int CW = $clog2(XLEN + 1);

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [CW-1:0]     cnt;

    // Exposing the next accumulator lets the caller capture the final product on the same edge as the last iteration.
    assign prod = acc + (mplier[0] ? mcand : '0);
    assign done = cnt == CW'(XLEN - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (step) begin
            acc    <= prod;
            mcand  <= {mcand[2*XLEN-2:0], 1'b0};
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mult_exec_unit.sv
// mult_exec_unit: iterative multiply unit between the issue queue and the CDB.
//   clk, rst                  - clock and asynchronous active-high reset
//   issue_valid, ex_done      - issue handshake; accepted when both are high
//   rs1_data, rs2_data        - operands
//   rd_tag                    - destination tag broadcast with the result
//   mul_op                    - MUL / MULH / MULHSU / MULHU
//   cdb_req, cdb_grant        - CDB request and arbiter grant
//   cdb_tag, cdb_data         - broadcast tag/result, zero when not valid
//   cdb_data_valid            - one-cycle broadcast pulse
module mult_exec_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = issue_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [TAG_W-1:0] rd_tag,
    input  logic [1:0]       mul_op,
    output logic             ex_done,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_data,
    output logic             cdb_data_valid
);
    import issue_pkg::*;

    typedef enum logic [1:0] {IDLE, BUSY, REQ, PUBLISH} mult_state_t;

    mult_state_t       state;
    mul_op_t           op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              neg_q;
    logic [XLEN-1:0]   result;
    logic              s1, s2, accept, done;
    logic [XLEN-1:0]   mag1, mag2;
    logic [2*XLEN-1:0] prod, full;
    logic [XLEN-1:0]   res;

    assign ex_done        = state == IDLE || state == PUBLISH;
    assign cdb_req        = state == REQ;
    assign cdb_data_valid = state == PUBLISH;
    assign accept         = issue_valid && ex_done;

    assign s1   = rs1_data[XLEN-1] && (mul_op == MULH || mul_op == MULHSU);
    assign s2   = rs2_data[XLEN-1] && mul_op == MULH;
    // The most-negative value negates to itself, which is its correct magnitude as an unsigned XLEN-bit number.
    assign mag1 = s1 ? -rs1_data : rs1_data;
    assign mag2 = s2 ? -rs2_data : rs2_data;
    assign full = neg_q ? -prod : prod;
    assign res  = op_q == MUL ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];

    mult_core #(.XLEN(XLEN)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .step  (state == BUSY),
        .a     (mag1),
        .b     (mag2),
        .prod  (prod),
        .done  (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= MUL;
            tag_q    <= '0;
            neg_q    <= 1'b0;
            result   <= '0;
            cdb_tag  <= '0;
            cdb_data <= '0;
        end else begin
            cdb_tag  <= '0;
            cdb_data <= '0;
            case (state)
                IDLE, PUBLISH: begin
                    state <= issue_valid ? BUSY : IDLE;
                    if (issue_valid) begin
                        tag_q <= rd_tag;
                        op_q  <= mul_op_t'(mul_op);
                        neg_q <= s1 ^ s2;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state  <= REQ;
                        result <= res;
                    end
                end
                REQ: begin
                    if (cdb_grant) begin
                        state    <= PUBLISH;
                        cdb_tag  <= tag_q;
                        cdb_data <= result;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_exec_unit.sv
// tb_mult_exec_unit: directed self-checking bench for mult_exec_unit.
module tb_mult_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [31:0] rs1_data, rs2_data;
    logic [5:0]  rd_tag;
    logic [1:0]  mul_op;
    logic        ex_done, cdb_req, cdb_grant, cdb_data_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_exec_unit #(.XLEN(32), .TAG_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .rd_tag         (rd_tag),
        .mul_op         (mul_op),
        .ex_done        (ex_done),
        .cdb_req        (cdb_req),
        .cdb_grant      (cdb_grant),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_data_valid (cdb_data_valid)
    );

    // Presents an instruction and returns #1 after its acceptance edge with issue_valid dropped.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
        issue_valid = 1'b1;
        mul_op      = op;
        rs1_data    = a;
        rs2_data    = b;
        rd_tag      = t;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    // Counts edges until cdb_data_valid is seen; gives up after 200.
    task automatic wait_valid(output int n, output logic busy_bad);
        n = 0;
        busy_bad = 1'b0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (cdb_data_valid) break;
            if (ex_done) busy_bad = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        issue_valid = 1'b0;
        cdb_grant = 1'b0;
        mul_op = 2'b00;
        rs1_data = '0;
        rs2_data = '0;
        rd_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (ex_done !== 1'b1) begin bad++; $display("FAIL reset_ex_done got=%b want=1", ex_done); end
        total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL reset_cdb_req got=%b want=0", cdb_req); end
        total++; if (cdb_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", cdb_data_valid); end
        total++; if (cdb_tag !== 6'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", cdb_tag); end
        total++; if (cdb_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", cdb_data); end
    endtask

    task automatic test_mul_basic;
        int n;
        logic bb;
        cdb_grant = 1'b1;
        start_op(2'b00, 32'd7, 32'd6, 6'd5);
        wait_valid(n, bb);
        total++; if (n + 1 !== 34) begin bad++; $display("FAIL mul_latency got=%0d want=34", n + 1); end
        total++; if (bb !== 1'b0) begin bad++; $display("FAIL mul_ex_done_busy got=%b want=0", bb); end
        total++; if (cdb_tag !== 6'd5) begin bad++; $display("FAIL mul_tag got=%0d want=5", cdb_tag); end
        total++; if (cdb_data !== 32'd42) begin bad++; $display("FAIL mul_data got=%0d want=42", cdb_data); end
        @(posedge clk);
        #1;
        total++; if (cdb_data_valid !== 1'b0) begin bad++; $display("FAIL mul_pulse got=%b want=0", cdb_data_valid); end
        total++; if (cdb_data !== 32'd0) begin bad++; $display("FAIL mul_data_clear got=%h want=0", cdb_data); end
    endtask

    task automatic test_high_half;
        logic [1:0]  ops [4] = '{2'b11, 2'b01, 2'b10, 2'b01};
        logic [31:0] as  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000};
        logic [31:0] bs  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003, 32'h80000000};
        logic [31:0] exp [4] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h40000000};
        int n;
        logic bb;
        cdb_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_op(ops[i], as[i], bs[i], 6'(10 + i));
            wait_valid(n, bb);
            total++;
            if (cdb_data !== exp[i] || cdb_tag !== 6'(10 + i) || n != 33) begin
                bad++;
                $display("FAIL high_half_%0d got data=%h tag=%0d lat=%0d want data=%h tag=%0d lat=34", i, cdb_data, cdb_tag, n + 1, exp[i], 10 + i);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_grant_stall;
        int n = 0;
        logic stall_bad = 1'b0;
        cdb_grant = 1'b0;
        start_op(2'b00, 32'd12, 32'd11, 6'd9);
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 32) begin
                issue_valid = 1'b1;
                rd_tag = 6'd15;
            end
            if (n >= 32 && n <= 36 && (cdb_req !== 1'b1 || cdb_data_valid !== 1'b0 || cdb_data !== 32'd0 || cdb_tag !== 6'd0 || ex_done !== 1'b0)) stall_bad = 1'b1;
            if (n == 37) begin
                issue_valid = 1'b0;
                cdb_grant = 1'b1;
            end
            if (cdb_data_valid) break;
        end
        total++; if (stall_bad !== 1'b0) begin bad++; $display("FAIL stall_hold got=%b want=0", stall_bad); end
        total++; if (n + 1 !== 39) begin bad++; $display("FAIL stall_latency got=%0d want=39", n + 1); end
        total++; if (cdb_tag !== 6'd9) begin bad++; $display("FAIL stall_tag got=%0d want=9", cdb_tag); end
        total++; if (cdb_data !== 32'd132) begin bad++; $display("FAIL stall_data got=%0d want=132", cdb_data); end
        @(posedge clk);
        #1;
        total++; if (ex_done !== 1'b1 || cdb_req !== 1'b0) begin bad++; $display("FAIL stall_idle got ex_done=%b req=%b want 1 0", ex_done, cdb_req); end
    endtask

    task automatic test_back_to_back;
        int n;
        int m = 0;
        logic bb;
        cdb_grant = 1'b1;
        issue_valid = 1'b1;
        mul_op = 2'b00;
        rs1_data = 32'd2;
        rs2_data = 32'd3;
        rd_tag = 6'd1;
        @(posedge clk);
        #1;
        rs1_data = 32'd4;
        rs2_data = 32'd5;
        rd_tag = 6'd2;
        wait_valid(n, bb);
        total++; if (cdb_tag !== 6'd1 || cdb_data !== 32'd6) begin bad++; $display("FAIL b2b_first got tag=%0d data=%0d want 1 6", cdb_tag, cdb_data); end
        while (m < 200) begin
            @(posedge clk);
            #1;
            m++;
            if (m == 1) begin
                total++; if (ex_done !== 1'b0) begin bad++; $display("FAIL b2b_accept_in_publish got ex_done=%b want=0", ex_done); end
                issue_valid = 1'b0;
            end
            if (cdb_data_valid) break;
        end
        total++; if (m !== 34) begin bad++; $display("FAIL b2b_spacing got=%0d want=34", m); end
        total++; if (cdb_tag !== 6'd2 || cdb_data !== 32'd20) begin bad++; $display("FAIL b2b_second got tag=%0d data=%0d want 2 20", cdb_tag, cdb_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_busy;
        int n;
        logic bb;
        logic seen = 1'b0;
        cdb_grant = 1'b1;
        start_op(2'b00, 32'hFFFF, 32'hFFFF, 6'd33);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (ex_done !== 1'b1 || cdb_req !== 1'b0 || cdb_data_valid !== 1'b0 || cdb_tag !== 6'd0 || cdb_data !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs got ex_done=%b req=%b valid=%b tag=%0d data=%h want 1 0 0 0 0", ex_done, cdb_req, cdb_data_valid, cdb_tag, cdb_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (cdb_data_valid || cdb_req || !ex_done) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_no_broadcast got=%b want=0", seen); end
        start_op(2'b00, 32'd3, 32'd3, 6'd7);
        wait_valid(n, bb);
        total++; if (n + 1 !== 34 || cdb_data !== 32'd9 || cdb_tag !== 6'd7) begin bad++; $display("FAIL rst_mid_fresh got lat=%0d data=%0d tag=%0d want 34 9 7", n + 1, cdb_data, cdb_tag); end
    endtask

    initial begin
        test_reset;
        test_mul_basic;
        test_high_half;
        test_grant_stall;
        test_back_to_back;
        test_reset_mid_busy;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
